ftdi_fifo_emulator: RTL and testbench

Synthesizable device-side model of the FT245-style asynchronous FIFO interface. The FPGA-side controller drives RD#/WR# and samples RXF#/TXE#; this block answers on those pins.
It holds a byte RX FIFO (host->controller) and a byte TX FIFO (controller->host). Each FIFO has a valid/ready streaming port on the host side.
Used for on-chip loopback of the FTDI controller and as the bench responder for it.

---
 rtl/ftdi_emu_pkg.sv | 6 +
 rtl/byte_sync_fifo.sv | 35 +++
 rtl/ftdi_fifo_emulator.sv | 121 ++++++++++++
 tb/tb_ftdi_fifo_emulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_emu_pkg.sv
// ftdi_emu_pkg: FSM encoding and widths shared by the FTDI FIFO emulator
package ftdi_emu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_PRECHARGE} state_e;
  localparam int SYNC_STAGES = 2;
  localparam int PRE_W = 4;
endpackage

// File: rtl/byte_sync_fifo.sv
// byte_sync_fifo: single-clock byte FIFO using extra-MSB pointers for full/empty
module byte_sync_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       in_clk,
  input  logic       in_reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  assign full = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign empty = wr_ptr_q == rd_ptr_q;
  assign head = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
  always_ff @(posedge in_clk or negedge in_reset_n)
    if (!in_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  always_ff @(posedge in_clk)
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
endmodule

// File: rtl/ftdi_fifo_emulator.sv
// ftdi_fifo_emulator: device-side FT245 async FIFO responder with host valid/ready byte streams
module ftdi_fifo_emulator
  import ftdi_emu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int PRECHARGE_CYCLES = 4
) (
  input  logic       in_clk,
  input  logic       in_reset_n,
  input  logic       in_ftdi_rd_n,
  input  logic       in_ftdi_wr_n,
  inout  wire  [7:0] io_ftdi_data,
  output logic       out_ftdi_rxf_n,
  output logic       out_ftdi_txe_n,
  input  logic [7:0] in_host_data,
  input  logic       in_host_valid,
  output logic       out_host_ready,
  output logic [7:0] out_host_data,
  output logic       out_host_valid,
  input  logic       in_host_ready,
  output logic       out_proto_err
);
  state_e state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
  logic rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic [7:0] data_prev_q, data_prev_d;
  logic rxf_n_q, rxf_n_d, txe_n_q, txe_n_d, proto_err_q, proto_err_d;
  logic rd_s, wr_s, rd_fall, rd_rise, wr_fall, wr_rise, rd_err, wr_err;
  logic rx_push, rx_pop, rx_full, rx_empty, tx_push, tx_pop, tx_full, tx_empty, bus_oe;
  logic [7:0] rx_head;
  always_comb begin
    rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], in_ftdi_rd_n};
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], in_ftdi_wr_n};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], io_ftdi_data};
    rd_s = rd_sync_q[SYNC_STAGES-1];
    wr_s = wr_sync_q[SYNC_STAGES-1];
    rd_prev_d = rd_s;
    wr_prev_d = wr_s;
    data_prev_d = data_sync_q[SYNC_STAGES-1];
    rd_fall = rd_prev_q && !rd_s;
    rd_rise = !rd_prev_q && rd_s;
    wr_fall = wr_prev_q && !wr_s;
    wr_rise = !wr_prev_q && wr_s;
  end
  // Flags lag the state by a cycle, so the state terms catch strobes in the first READ/WRITE cycle
  always_comb begin
    rd_err = rd_fall && (rxf_n_q || !wr_s || state_q == ST_WRITE);
    wr_err = wr_fall && (txe_n_q || !rd_s || state_q == ST_READ);
    proto_err_d = proto_err_q || rd_err || wr_err || (!rd_s && !wr_s);
    state_d = state_q;
    pre_cnt_d = pre_cnt_q;
    rx_pop = 1'b0;
    tx_push = 1'b0;
    case (state_q)
      ST_IDLE: state_d = (rd_fall && !rd_err) ? ST_READ : (wr_fall && !wr_err) ? ST_WRITE : ST_IDLE;
      ST_READ: begin
        rx_pop = rd_rise;
        state_d = rd_rise ? ST_PRECHARGE : ST_READ;
        pre_cnt_d = PRE_W'(PRECHARGE_CYCLES - 1);
      end
      ST_WRITE: begin
        tx_push = wr_rise;
        state_d = wr_rise ? ST_PRECHARGE : ST_WRITE;
        pre_cnt_d = PRE_W'(PRECHARGE_CYCLES - 1);
      end
      default: begin
        state_d = (pre_cnt_q == '0) ? ST_IDLE : ST_PRECHARGE;
        pre_cnt_d = pre_cnt_q - PRE_W'(1);
      end
    endcase
  end
  always_comb begin
    rxf_n_d = !(state_q == ST_IDLE && !rx_empty);
    txe_n_d = !(state_q == ST_IDLE && !tx_full);
  end
  assign bus_oe = state_q == ST_READ && !rd_rise;
  assign io_ftdi_data = bus_oe ? rx_head : 8'hzz;
  assign out_ftdi_rxf_n = rxf_n_q;
  assign out_ftdi_txe_n = txe_n_q;
  assign out_proto_err = proto_err_q;
  assign out_host_ready = in_reset_n && !rx_full;
  assign out_host_valid = !tx_empty;
  assign rx_push = in_host_valid && out_host_ready;
  assign tx_pop = out_host_valid && in_host_ready;
  always_ff @(posedge in_clk or negedge in_reset_n)
    if (!in_reset_n) begin
      state_q <= ST_IDLE;
      pre_cnt_q <= '0;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      data_sync_q <= '0;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
      data_prev_q <= '0;
      rxf_n_q <= 1'b1;
      txe_n_q <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_cnt_q <= pre_cnt_d;
      rd_sync_q <= rd_sync_d;
      wr_sync_q <= wr_sync_d;
      data_sync_q <= data_sync_d;
      rd_prev_q <= rd_prev_d;
      wr_prev_q <= wr_prev_d;
      data_prev_q <= data_prev_d;
      rxf_n_q <= rxf_n_d;
      txe_n_q <= txe_n_d;
      proto_err_q <= proto_err_d;
    end
  byte_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .push(rx_push), .push_data(in_host_data),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );
  byte_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .push(tx_push), .push_data(data_prev_q),
    .pop(tx_pop), .head(out_host_data), .full(tx_full), .empty(tx_empty)
  );
endmodule

// File: tb/tb_ftdi_fifo_emulator.sv
// tb_ftdi_fifo_emulator: vector table, corner sequences and queue-model random run
module tb_ftdi_fifo_emulator;
  typedef enum logic [1:0] {OP_PUSH, OP_READ, OP_WRITE, OP_POP} op_e;
  typedef struct {op_e op; logic [7:0] din; logic [7:0] exp_d; logic exp_f;} vec_t;
  logic in_clk = 0, in_reset_n = 0, rd_n = 1, wr_n = 1, tb_oe = 0;
  logic [7:0] tb_bus = 0, host_data = 0, h_data, gd, rb;
  logic host_valid = 0, host_ready = 0, rxf_n, txe_n, h_ready, h_valid, perr, gf;
  wire [7:0] io_ftdi_data;
  int total = 0, bad = 0, op;
  vec_t vecs[12];
  logic [7:0] rxq[$], txq[$];
  assign io_ftdi_data = tb_oe ? tb_bus : 8'hzz;
  always #5 in_clk = ~in_clk;
  ftdi_fifo_emulator #(.DEPTH_LOG2(4), .PRECHARGE_CYCLES(4)) dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .in_ftdi_rd_n(rd_n), .in_ftdi_wr_n(wr_n),
    .io_ftdi_data(io_ftdi_data), .out_ftdi_rxf_n(rxf_n), .out_ftdi_txe_n(txe_n),
    .in_host_data(host_data), .in_host_valid(host_valid), .out_host_ready(h_ready),
    .out_host_data(h_data), .out_host_valid(h_valid), .in_host_ready(host_ready),
    .out_proto_err(perr)
  );
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic wait_low(input string name, input bit rx);
    int n = 0;
    while ((rx ? rxf_n : txe_n) && n < 100) begin
      tick();
      n++;
    end
    chk(name, rx ? rxf_n : txe_n, 0);
  endtask
  task automatic do_reset();
    rd_n = 1; wr_n = 1; tb_oe = 0; host_valid = 0; host_ready = 0;
    in_reset_n = 0;
    repeat (2) tick();
    in_reset_n = 1;
    repeat (2) tick();
  endtask
  task automatic host_push(input logic [7:0] d);
    host_data = d; host_valid = 1;
    tick();
    host_valid = 0;
  endtask
  task automatic host_pop(output logic [7:0] d);
    d = h_data; host_ready = 1;
    tick();
    host_ready = 0;
  endtask
  task automatic ctrl_read(output logic [7:0] d);
    wait_low("rxf_n before read", 1);
    rd_n = 0;
    repeat (3) tick();
    chk("bus driven in read", dut.bus_oe, 1);
    d = io_ftdi_data;
    repeat (3) tick();
    rd_n = 1;
    repeat (2) tick();
    chk("bus released after read", dut.bus_oe, 0);
    repeat (6) tick();
  endtask
  task automatic ctrl_write(input logic [7:0] d);
    wait_low("txe_n before write", 0);
    tb_oe = 1; tb_bus = d; wr_n = 0;
    repeat (6) tick();
    wr_n = 1; tb_bus = ~d;
    repeat (2) tick();
    tb_oe = 0;
    repeat (6) tick();
  endtask
  initial begin
    vecs[0]  = '{OP_PUSH,  8'hA5, 8'h01, 1'b0};
    vecs[1]  = '{OP_READ,  8'h00, 8'hA5, 1'b1};
    vecs[2]  = '{OP_WRITE, 8'h3C, 8'h3C, 1'b1};
    vecs[3]  = '{OP_POP,   8'h00, 8'h3C, 1'b0};
    vecs[4]  = '{OP_PUSH,  8'h11, 8'h01, 1'b0};
    vecs[5]  = '{OP_PUSH,  8'h22, 8'h01, 1'b0};
    vecs[6]  = '{OP_READ,  8'h00, 8'h11, 1'b0};
    vecs[7]  = '{OP_READ,  8'h00, 8'h22, 1'b1};
    vecs[8]  = '{OP_WRITE, 8'h5A, 8'h5A, 1'b1};
    vecs[9]  = '{OP_WRITE, 8'h6B, 8'h5A, 1'b1};
    vecs[10] = '{OP_POP,   8'h00, 8'h5A, 1'b1};
    vecs[11] = '{OP_POP,   8'h00, 8'h6B, 1'b0};
    repeat (2) tick();
    chk("reset rxf_n", rxf_n, 1);
    chk("reset txe_n", txe_n, 1);
    chk("reset bus released", dut.bus_oe, 0);
    chk("reset host_valid", h_valid, 0);
    chk("reset host_ready", h_ready, 0);
    chk("reset proto_err", perr, 0);
    in_reset_n = 1;
    repeat (3) tick();
    chk("post-reset host_ready", h_ready, 1);
    chk("post-reset txe_n", txe_n, 0);
    chk("post-reset rxf_n", rxf_n, 1);
    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_PUSH:  begin host_push(vecs[i].din); tick(); gd = {7'b0, h_ready}; gf = rxf_n; end
        OP_READ:  begin ctrl_read(gd); gf = rxf_n; end
        OP_WRITE: begin ctrl_write(vecs[i].din); gd = h_data; gf = h_valid; end
        default:  begin host_pop(gd); gf = h_valid; end
      endcase
      chk($sformatf("vec%0d data", i), gd, vecs[i].exp_d);
      chk($sformatf("vec%0d flag", i), gf, vecs[i].exp_f);
    end
    host_push(8'h71);
    host_push(8'h72);
    wait_low("rxf_n before precharge read", 1);
    rd_n = 0;
    repeat (3) tick();
    chk("precharge read data", io_ftdi_data, 8'h71);
    repeat (3) tick();
    rd_n = 1;
    repeat (7) tick();
    chk("rxf_n held through precharge", rxf_n, 1);
    tick();
    chk("rxf_n low after precharge", rxf_n, 0);
    ctrl_read(gd);
    chk("second precharge byte", gd, 8'h72);
    repeat (4) tick();
    chk("rxf_n stays high when empty", rxf_n, 1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) host_push(8'(i));
      chk("host_ready low when full", h_ready, 0);
      host_push(8'hFF);
      for (int i = 0; i < 16; i++) begin
        ctrl_read(gd);
        chk("rx fill order", gd, 8'(i));
      end
      chk("rxf_n high after drain", rxf_n, 1);
    end
    host_ready = 0;
    for (int i = 0; i < 16; i++) ctrl_write(8'h80 + 8'(i));
    chk("txe_n high when tx full", txe_n, 1);
    chk("no proto_err before overflow", perr, 0);
    wr_n = 0;
    repeat (4) tick();
    chk("proto_err on write while full", perr, 1);
    wr_n = 1;
    repeat (8) tick();
    for (int i = 0; i < 16; i++) begin
      host_pop(gd);
      chk("tx fill order", gd, 8'h80 + 8'(i));
    end
    chk("tx held exactly 16", h_valid, 0);
    do_reset();
    host_push(8'h5E);
    wait_low("rxf_n before dual strobe", 1);
    rd_n = 0; wr_n = 0;
    repeat (4) tick();
    chk("proto_err on dual strobe", perr, 1);
    chk("bus released on dual strobe", dut.bus_oe, 0);
    rd_n = 1; wr_n = 1;
    repeat (10) tick();
    ctrl_read(gd);
    chk("byte kept after dual strobe", gd, 8'h5E);
    chk("rx held one byte", rxf_n, 1);
    do_reset();
    host_push(8'h99);
    wait_low("rxf_n before reset read", 1);
    rd_n = 0;
    repeat (4) tick();
    chk("bus driven before reset", dut.bus_oe, 1);
    in_reset_n = 0;
    #1;
    chk("bus released in reset", dut.bus_oe, 0);
    chk("rxf_n high in reset", rxf_n, 1);
    chk("host_ready low in reset", h_ready, 0);
    rd_n = 1;
    repeat (2) tick();
    in_reset_n = 1;
    repeat (12) tick();
    chk("rx empty after reset", rxf_n, 1);
    chk("host_ready after reset", h_ready, 1);
    chk("proto_err cleared by reset", perr, 0);
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 3);
      rb = 8'($urandom);
      case (op)
        0: begin
          chk("rnd host_ready", h_ready, rxq.size() < 16);
          if (rxq.size() < 16) begin host_push(rb); rxq.push_back(rb); end
        end
        1: if (rxq.size() > 0) begin
          ctrl_read(gd);
          chk("rnd read data", gd, rxq.pop_front());
        end else chk("rnd rxf_n when empty", rxf_n, 1);
        2: if (txq.size() < 16) begin
          ctrl_write(rb);
          txq.push_back(rb);
        end else chk("rnd txe_n when full", txe_n, 1);
        default: begin
          chk("rnd host_valid", h_valid, txq.size() > 0);
          if (txq.size() > 0) begin
            host_pop(gd);
            chk("rnd pop data", gd, txq.pop_front());
          end
        end
      endcase
    end
    chk("no proto_err in random run", perr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
